fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch controller on the consuming side of the Fetch-stage PC register. It takes pcF and issues word reads to instruction memory over a req/ack handshake. It drives StallF back to the PC register until the word returns, then presents the instruction and PC+4 to the Decode pipeline register. It also handles Decode-side stalls (StallD) and branch/jump redirects (PCSrcD), discarding wrong-path responses.

## Interface
- No parameters; all datapaths are 32 bits.
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  reset; asynchronous, active-high.
- pcF  in  32  current Fetch PC from the PC pipeline register.
- PCSrcD  in  1  redirect: a branch or jump is taken in Decode; the current fetch is wrong-path.
- StallD  in  1  Decode register is holding; instrF, validF and pcPlus4F must not change.
- StallF  out  1  combinational; 1 = PC register must hold pcF.
- mem_req  out  1  read request to instruction memory.
- mem_addr  out  32  word address, bits [1:0] always 0.
- mem_ack  in  1  read complete; mem_rdata is valid in the same cycle.
- mem_rdata  in  32  instruction word.
- instrF  out  32  registered fetched instruction to the Decode register.
- pcPlus4F  out  32  registered pcF+4 matching instrF.
- validF  out  1  registered; 0 = bubble (instrF must be treated as NOP).

## Operation
- **States:** FETCH, HOLD, DISCARD. Reset state is FETCH.
- **Registers:** buf_q (32), addr_q (32).
- **Memory protocol:**
  - Once mem_req=1, mem_req and mem_addr stay stable until the cycle in which mem_ack=1.
  - mem_ack may arrive in the same cycle as the request (zero wait states).
  - mem_ack is ignored when mem_req=0.
- **FETCH:** mem_req=1, mem_addr={pcF[31:2],2'b00}; addr_q<=mem_addr every cycle. Priority order:
  1. PCSrcD=1:
     - StallF=0; validF<=0.
     - If mem_ack=1, the response is dropped and the state stays FETCH.
     - Otherwise go to DISCARD.
  2. mem_ack=1 and StallD=1: buf_q<=mem_rdata; StallF=1; go to HOLD.
  3. mem_ack=1 and StallD=0: instrF<=mem_rdata; pcPlus4F<=pcF+4; validF<=1; StallF=0.
  4. mem_ack=0:
     - StallF=1.
     - If StallD=0: validF<=0 (bubble); instrF and pcPlus4F hold.
     - If StallD=1: all outputs hold.
- **HOLD:** mem_req=0.
  - PCSrcD=1: buf_q dropped; StallF=0; validF<=0; go to FETCH.
  - Else StallD=1: StallF=1; hold.
  - Else: instrF<=buf_q; pcPlus4F<=pcF+4; validF<=1; StallF=0; go to FETCH.
- **DISCARD:** mem_req=1, mem_addr=addr_q (the abandoned address); StallF=1; PCSrcD and StallD are ignored.
  - If StallD=0: validF<=0.
  - On mem_ack: data dropped; go to FETCH (the target is fetched next).
- **Arithmetic:** pcPlus4F = pcF+4 modulo 2^32, so 0xFFFFFFFC yields 0x00000000.

## Timing
- **Reset (asynchronous):**
  - state=FETCH; instrF=0; pcPlus4F=0; validF=0; buf_q=0; addr_q=0.
  - mem_req=0 while RST=1.
  - The first request is issued in the first cycle after RST deasserts.
- **Reset mid-transaction:** the outstanding request is abandoned with no DISCARD. Instruction memory shares RST, so no stale ack arrives.
- **Latency:** with zero wait states, instrF/validF update at the edge ending the ack cycle. Throughput is one instruction per cycle.
- **Wait states:** N wait states give N bubbles (validF=0) into Decode and N cycles of StallF=1.
- **Redirect:**
  - A redirect during a wait costs the remaining wait time in DISCARD plus one fresh fetch.
  - A redirect coincident with mem_ack costs no extra cycle.
- **Signal timing:** StallF is purely combinational from state, mem_ack, StallD and PCSrcD. instrF, pcPlus4F and validF change only at CLK edges.

## Test plan
- **Zero-wait stream:** pcF 0x00400030→0x00400034→0x00400038, mem_ack=1 every cycle -> StallF=0 throughout; instrF follows mem_rdata one cycle later; pcPlus4F=0x00400034, 0x00400038, 0x0040003C; validF=1.
- **Two wait states:** pcF=0x00400030, ack on the third cycle with rdata 0x8C080004 -> StallF=1 for 2 cycles; validF=0 for 2 edges; then instrF=0x8C080004, pcPlus4F=0x00400034, validF=1.
- **Redirect while waiting:**
  - Stimulus: PCSrcD=1 at pcF=0x00400040 with no ack.
  - Required: StallF=0 that cycle; DISCARD holds mem_addr=0x00400040 until ack; the response is dropped.
  - Required next: a new request to the new pcF (target 0x00400100); validF=0 until it returns.
- **Stall with ack:** StallD=1 while ack returns 0x012A4020 -> HOLD; mem_req=0; StallF=1; outputs frozen. StallD falls -> instrF=0x012A4020, validF=1, StallF=0.
- **Reset mid-wait:** RST asserted mid-request -> validF=0, instrF=0 and mem_req=0 immediately without a clock edge; after release, a request to the current pcF.
- **Wrap-around:** pcF=0xFFFFFFFC with ack -> pcPlus4F=0x00000000, mem_addr=0xFFFFFFFC.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch controller between the Fetch-stage PC register
// and the Decode pipeline register. Issues word reads over a req/ack handshake,
// stalls the PC register until the word returns, parks an early word while
// Decode is stalled, and flushes wrong-path responses after a redirect.
module fetch_ctrl (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] pcF,
    input  logic        PCSrcD,
    input  logic        StallD,
    output logic        StallF,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instrF,
    output logic [31:0] pcPlus4F,
    output logic        validF
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state_r;
    logic [31:0] buf_q;
    logic [31:0] addr_q;

    logic [31:0] pc_word_s;
    logic [31:0] pc_plus4_s;
    logic        stall_s;
    logic        req_s;
    logic [31:0] addr_s;

    // Word-aligned fetch address and the sequential successor (wraps mod 2^32).
    assign pc_word_s  = {pcF[31:2], 2'b00};
    assign pc_plus4_s = pcF + 32'd4;

    // Request/stall decode from state and the current handshake inputs.
    always_comb begin
        stall_s = 1'b1;
        req_s   = 1'b0;
        addr_s  = pc_word_s;
        case (state_r)
            FETCH: begin
                req_s  = 1'b1;
                addr_s = pc_word_s;
                if (PCSrcD) begin
                    // Redirect: let the PC register load the target now.
                    stall_s = 1'b0;
                end else if (mem_ack) begin
                    // Word arrived; stall only if it must be parked.
                    stall_s = StallD;
                end else begin
                    stall_s = 1'b1;
                end
            end
            HOLD: begin
                req_s  = 1'b0;
                addr_s = pc_word_s;
                if (PCSrcD) begin
                    stall_s = 1'b0;
                end else begin
                    stall_s = StallD;
                end
            end
            DISCARD: begin
                // Keep the abandoned request stable until memory answers it.
                req_s   = 1'b1;
                addr_s  = addr_q;
                stall_s = 1'b1;
            end
            default: begin
                req_s   = 1'b0;
                addr_s  = pc_word_s;
                stall_s = 1'b1;
            end
        endcase
    end

    // No request may be visible while the shared reset is asserted.
    assign StallF   = stall_s;
    assign mem_req  = req_s & ~RST;
    assign mem_addr = addr_s;

    // Fetch FSM with registered Decode-side outputs and parking buffer.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r  <= FETCH;
            instrF   <= 32'd0;
            pcPlus4F <= 32'd0;
            validF   <= 1'b0;
            buf_q    <= 32'd0;
            addr_q   <= 32'd0;
        end else begin
            case (state_r)
                FETCH: begin
                    addr_q <= pc_word_s;
                    if (PCSrcD) begin
                        validF <= 1'b0;
                        if (mem_ack) begin
                            state_r <= FETCH;
                        end else begin
                            state_r <= DISCARD;
                        end
                    end else if (mem_ack && StallD) begin
                        buf_q   <= mem_rdata;
                        state_r <= HOLD;
                    end else if (mem_ack) begin
                        instrF   <= mem_rdata;
                        pcPlus4F <= pc_plus4_s;
                        validF   <= 1'b1;
                    end else if (!StallD) begin
                        validF <= 1'b0;
                    end else begin
                        validF <= validF;
                    end
                end
                HOLD: begin
                    if (PCSrcD) begin
                        validF  <= 1'b0;
                        state_r <= FETCH;
                    end else if (StallD) begin
                        state_r <= HOLD;
                    end else begin
                        // pcF was held by StallF, so it still matches buf_q.
                        instrF   <= buf_q;
                        pcPlus4F <= pc_plus4_s;
                        validF   <= 1'b1;
                        state_r  <= FETCH;
                    end
                end
                DISCARD: begin
                    if (!StallD) begin
                        validF <= 1'b0;
                    end else begin
                        validF <= validF;
                    end
                    if (mem_ack) begin
                        state_r <= FETCH;
                    end else begin
                        state_r <= DISCARD;
                    end
                end
                default: begin
                    state_r <= FETCH;
                    validF  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed bench for fetch_ctrl. Delivered words are pushed to
// a scoreboard queue when the ack is driven and popped when validF shows them.
module tb_fetch_ctrl;

    logic        CLK;
    logic        RST;
    logic [31:0] pcF;
    logic        PCSrcD;
    logic        StallD;
    logic        StallF;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] instrF;
    logic [31:0] pcPlus4F;
    logic        validF;

    int checks = 0;
    int errors = 0;

    logic [63:0] sb_q[$];
    logic [31:0] last_instr = 32'd0;
    logic [31:0] last_pc4   = 32'd0;

    fetch_ctrl dut (
        .CLK      (CLK),
        .RST      (RST),
        .pcF      (pcF),
        .PCSrcD   (PCSrcD),
        .StallD   (StallD),
        .StallF   (StallF),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .instrF   (instrF),
        .pcPlus4F (pcPlus4F),
        .validF   (validF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Drive one cycle of inputs, check combinational outputs, then clock it.
    task automatic cycle(input logic [31:0] pc, input logic pcsrc, input logic stalld,
                         input logic ack, input logic [31:0] rdata,
                         input logic exp_stallf, input logic exp_req,
                         input logic chk_addr, input logic [31:0] exp_addr);
        pcF       = pc;
        PCSrcD    = pcsrc;
        StallD    = stalld;
        mem_ack   = ack;
        mem_rdata = rdata;
        #1;
        chk("StallF", {31'd0, StallF}, {31'd0, exp_stallf});
        chk("mem_req", {31'd0, mem_req}, {31'd0, exp_req});
        if (chk_addr) chk("mem_addr", mem_addr, exp_addr);
        @(posedge CLK);
        #1;
    endtask

    // Check registered outputs after an edge; a valid word pops the scoreboard.
    task automatic post(input logic exp_valid);
        logic [63:0] e;
        chk("validF", {31'd0, validF}, {31'd0, exp_valid});
        if (exp_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_underflow: observed empty queue expected an entry");
            end else begin
                e = sb_q.pop_front();
                chk("instrF", instrF, e[63:32]);
                chk("pcPlus4F", pcPlus4F, e[31:0]);
                last_instr = e[63:32];
                last_pc4   = e[31:0];
            end
        end
    endtask

    // Outputs frozen by a Decode stall: still the last delivered word.
    task automatic post_hold();
        chk("validF_hold", {31'd0, validF}, 32'd1);
        chk("instrF_hold", instrF, last_instr);
        chk("pcPlus4F_hold", pcPlus4F, last_pc4);
    endtask

    initial begin
        RST       = 1'b1;
        pcF       = 32'h0040_0030;
        PCSrcD    = 1'b0;
        StallD    = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        #2;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_validF", {31'd0, validF}, 32'd0);
        chk("rst_instrF", instrF, 32'd0);
        chk("rst_pcPlus4F", pcPlus4F, 32'd0);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Zero-wait stream: one instruction per cycle, no stall.
        cycle(32'h0040_0030, 1'b0, 1'b0, 1'b1, 32'h1111_0001, 1'b0, 1'b1, 1'b1, 32'h0040_0030);
        sb_q.push_back({32'h1111_0001, 32'h0040_0034});
        post(1'b1);
        cycle(32'h0040_0034, 1'b0, 1'b0, 1'b1, 32'h1111_0002, 1'b0, 1'b1, 1'b1, 32'h0040_0034);
        sb_q.push_back({32'h1111_0002, 32'h0040_0038});
        post(1'b1);
        cycle(32'h0040_0038, 1'b0, 1'b0, 1'b1, 32'h1111_0003, 1'b0, 1'b1, 1'b1, 32'h0040_0038);
        sb_q.push_back({32'h1111_0003, 32'h0040_003C});
        post(1'b1);

        // Two wait states: two stalled cycles, two bubbles, then the word.
        cycle(32'h0040_0030, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0040_0030);
        post(1'b0);
        cycle(32'h0040_0030, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0040_0030);
        post(1'b0);
        cycle(32'h0040_0030, 1'b0, 1'b0, 1'b1, 32'h8C08_0004, 1'b0, 1'b1, 1'b1, 32'h0040_0030);
        sb_q.push_back({32'h8C08_0004, 32'h0040_0034});
        post(1'b1);

        // Redirect while waiting: DISCARD keeps the old address, drops its data.
        cycle(32'h0040_0040, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0040_0040);
        post(1'b0);
        cycle(32'h0040_0100, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0040_0040);
        post(1'b0);
        cycle(32'h0040_0100, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 32'h0040_0040);
        post(1'b0);
        cycle(32'h0040_0100, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0040_0100);
        post(1'b0);
        cycle(32'h0040_0100, 1'b0, 1'b0, 1'b1, 32'h2008_0001, 1'b0, 1'b1, 1'b1, 32'h0040_0100);
        sb_q.push_back({32'h2008_0001, 32'h0040_0104});
        post(1'b1);

        // Redirect coincident with ack: response dropped, no extra cycle.
        cycle(32'h0040_0104, 1'b1, 1'b0, 1'b1, 32'hBADB_AD00, 1'b0, 1'b1, 1'b1, 32'h0040_0104);
        post(1'b0);
        cycle(32'h0040_0200, 1'b0, 1'b0, 1'b1, 32'h0000_0002, 1'b0, 1'b1, 1'b1, 32'h0040_0200);
        sb_q.push_back({32'h0000_0002, 32'h0040_0204});
        post(1'b1);

        // Stall with ack: word parked in HOLD, stray ack ignored, then released.
        cycle(32'h0040_0204, 1'b0, 1'b1, 1'b1, 32'h012A_4020, 1'b1, 1'b1, 1'b1, 32'h0040_0204);
        post_hold();
        cycle(32'h0040_0204, 1'b0, 1'b1, 1'b1, 32'hFFFF_0000, 1'b1, 1'b0, 1'b0, 32'h0);
        post_hold();
        cycle(32'h0040_0204, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        sb_q.push_back({32'h012A_4020, 32'h0040_0208});
        post(1'b1);

        // Decode stall during a wait: outputs hold, no bubble inserted.
        cycle(32'h0040_0208, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0040_0208);
        post_hold();
        cycle(32'h0040_0208, 1'b0, 1'b0, 1'b1, 32'h0000_0033, 1'b0, 1'b1, 1'b1, 32'h0040_0208);
        sb_q.push_back({32'h0000_0033, 32'h0040_020C});
        post(1'b1);

        // Wrap-around of the PC+4 adder.
        cycle(32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1, 32'h0000_0044, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        sb_q.push_back({32'h0000_0044, 32'h0000_0000});
        post(1'b1);

        // Reset mid-wait: outputs clear immediately, fresh fetch afterwards.
        cycle(32'h0040_0500, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0040_0500);
        post_hold();
        RST = 1'b1;
        #1;
        chk("midrst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("midrst_validF", {31'd0, validF}, 32'd0);
        chk("midrst_instrF", instrF, 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        cycle(32'h0040_0500, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0040_0500);
        post(1'b0);
        cycle(32'h0040_0500, 1'b0, 1'b0, 1'b1, 32'h0000_0055, 1'b0, 1'b1, 1'b1, 32'h0040_0500);
        sb_q.push_back({32'h0000_0055, 32'h0040_0504});
        post(1'b1);

        chk("sb_empty", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
